// File: rtl/dcache_if.sv
// dcache_if: bundle of the CPU load/store port and the memory port of dcache.
//   slave  : used by dcache (takes requests and mem_RD, drives RD/stall/strobes)
//   master : used by the environment that plays both CPU and data memory
// Signals:
//   MemRead, MemWrite, funct3, A, WD  CPU request
//   RD, stall                          CPU response
//   fetch, mem_A, mem_RD               memory read port (mem_RD combinational)
//   writeback, WB_addr, WB_DATA        memory write port (written on the same edge)
interface dcache_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] WD;
    logic [DATA_WIDTH-1:0] RD;
    logic                  stall;
    logic                  fetch;
    logic [DATA_WIDTH-1:0] mem_A;
    logic [DATA_WIDTH-1:0] mem_RD;
    logic                  writeback;
    logic [DATA_WIDTH-1:0] WB_addr;
    logic [DATA_WIDTH-1:0] WB_DATA;

    modport master (
        output MemRead, MemWrite, funct3, A, WD, mem_RD,
        input  RD, stall, fetch, mem_A, writeback, WB_addr, WB_DATA
    );

    modport slave (
        input  MemRead, MemWrite, funct3, A, WD, mem_RD,
        output RD, stall, fetch, mem_A, writeback, WB_addr, WB_DATA
    );
endinterface

// File: rtl/dcache.sv
// dcache: two-way set-associative, write-back, write-allocate data cache with
// one-word blocks. Hits complete in the request cycle; a miss optionally writes
// back a dirty victim, fetches the word, then completes as a hit in IDLE.
// Address 0x000000FC is an MMIO trigger that bypasses the cache.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  dcache_if.slave (CPU request/response and memory fetch/writeback)
module dcache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 256
) (
    input  logic     clk,
    input  logic     rst,
    dcache_if.slave  bus
);
    localparam int IW = $clog2(SETS);
    localparam int TW = DATA_WIDTH - IW - 2;
    localparam logic [DATA_WIDTH-1:0] MMIO_ADDR = DATA_WIDTH'(32'h0000_00FC);

    // state     | meaning
    // IDLE      | serve hits / MMIO, detect misses
    // WRITEBACK | write dirty victim word to memory
    // ALLOCATE  | fetch missing word into victim way
    typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2} state_t;

    state_t state_q, state_d;
    logic   victim_q, victim_d;

    logic [1:0][SETS-1:0]  valid_q;
    logic [1:0][SETS-1:0]  dirty_q;
    logic [SETS-1:0]       lru_q;
    logic [TW-1:0]         tag_q  [2][SETS];
    logic [DATA_WIDTH-1:0] data_q [2][SETS];

    logic [IW-1:0]         idx;
    logic [TW-1:0]         tag;
    logic [1:0]            off;
    logic                  req, is_store, is_load, mmio;
    logic                  hit0, hit1, hit, hit_way, victim_sel, store_ok;
    logic [DATA_WIDTH-1:0] hit_word, merged, load_val;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    logic                  wr_en, wr_way, wr_dirty;
    logic [TW-1:0]         wr_tag;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  lru_we, lru_d;

    logic                  stall, fetch, writeback;
    logic [DATA_WIDTH-1:0] rd, mem_a, wb_addr, wb_data;

    assign idx      = bus.A[IW+1:2];
    assign tag      = bus.A[DATA_WIDTH-1:IW+2];
    assign off      = bus.A[1:0];
    assign req      = bus.MemRead | bus.MemWrite;
    assign is_store = bus.MemWrite;
    assign is_load  = bus.MemRead & ~bus.MemWrite;
    assign mmio     = (bus.A == MMIO_ADDR);

    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = ~hit0;
    assign hit_word = data_q[hit_way][idx];

    // Invalid ways are filled first; only a full set consults the LRU bit.
    assign victim_sel = !valid_q[0][idx] ? 1'b0 :
                        !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    always_comb begin
        ld_byte  = hit_word[{off, 3'b000} +: 8];
        ld_half  = bus.A[1] ? hit_word[31:16] : hit_word[15:0];
        load_val = '0;
        case (bus.funct3)
            3'b000:  load_val = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b010:  load_val = hit_word;
            3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        merged   = hit_word;
        store_ok = 1'b1;
        case (bus.funct3)
            3'b000:  merged[{off, 3'b000} +: 8]       = bus.WD[7:0];
            3'b001:  merged[{bus.A[1], 4'b0000} +: 16] = bus.WD[15:0];
            3'b010:  merged = bus.WD;
            default: store_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        wr_en     = 1'b0;
        wr_way    = victim_q;
        wr_dirty  = 1'b0;
        wr_tag    = tag;
        wr_data   = bus.mem_RD;
        lru_we    = 1'b0;
        lru_d     = lru_q[idx];
        stall     = 1'b0;
        fetch     = 1'b0;
        writeback = 1'b0;
        rd        = '0;
        mem_a     = '0;
        wb_addr   = '0;
        wb_data   = '0;
        case (state_q)
            IDLE: begin
                if (mmio) begin
                    mem_a = bus.A;
                    if (is_load) rd = bus.mem_RD;
                end else if (req && hit) begin
                    lru_we = 1'b1;
                    lru_d  = ~hit_way;
                    if (is_load) rd = load_val;
                    if (is_store && store_ok) begin
                        wr_en    = 1'b1;
                        wr_way   = hit_way;
                        wr_dirty = 1'b1;
                        wr_data  = merged;
                    end
                end else if (req) begin
                    stall    = 1'b1;
                    victim_d = victim_sel;
                    state_d  = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx])
                               ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                stall     = 1'b1;
                writeback = 1'b1;
                wb_addr   = {tag_q[victim_q][idx], idx, 2'b00};
                wb_data   = data_q[victim_q][idx];
                state_d   = ALLOCATE;
            end
            ALLOCATE: begin
                stall   = 1'b1;
                fetch   = 1'b1;
                mem_a   = {bus.A[DATA_WIDTH-1:2], 2'b00};
                wr_en   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced quiet while reset is held, even with a request pending.
        if (rst) begin
            wr_en     = 1'b0;
            lru_we    = 1'b0;
            stall     = 1'b0;
            fetch     = 1'b0;
            writeback = 1'b0;
            rd        = '0;
            mem_a     = '0;
            wb_addr   = '0;
            wb_data   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (wr_en) begin
                valid_q[wr_way][idx] <= 1'b1;
                dirty_q[wr_way][idx] <= wr_dirty;
            end
            if (lru_we) lru_q[idx] <= lru_d;
        end
    end

    // Tag/data storage carries no reset; it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_way][idx]  <= wr_tag;
            data_q[wr_way][idx] <= wr_data;
        end
    end

    assign bus.stall     = stall;
    assign bus.fetch     = fetch;
    assign bus.writeback = writeback;
    assign bus.RD        = rd;
    assign bus.mem_A     = mem_a;
    assign bus.WB_addr   = wb_addr;
    assign bus.WB_DATA   = wb_data;
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed self-checking bench for dcache. Plays CPU and a word
// memory; expected load results go through a scoreboard queue.
module tb_dcache;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_if bus();

    dcache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:65535];
    logic [31:0] trigger;
    assign bus.mem_RD = (bus.mem_A == 32'h0000_00FC) ? trigger : mem[bus.mem_A[17:2]];

    always @(posedge clk) begin
        if (bus.writeback) mem[bus.WB_addr[17:2]] = bus.WB_DATA;
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int fetch_cnt = 0;
    int wb_cnt = 0;
    logic [31:0] fetch_addr = '0;
    logic [31:0] wb_addr_seen = '0;
    logic [31:0] wb_data_seen = '0;

    always @(negedge clk) begin
        if (bus.fetch) begin
            fetch_cnt++;
            fetch_addr = bus.mem_A;
        end
        if (bus.writeback) begin
            wb_cnt++;
            wb_addr_seen = bus.WB_addr;
            wb_data_seen = bus.WB_DATA;
        end
        if (bus.fetch && bus.writeback) check("strobe_excl", 32'd1, 32'd0);
    end

    // Drive one request at a negedge, count stall cycles, then compare RD in
    // the completing cycle. The request stays up across the completing edge.
    task automatic access(input string tag, input logic wr, input logic rd_en,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input int exp_stalls);
        int n;
        logic [31:0] got;
        @(negedge clk);
        bus.MemWrite = wr;
        bus.MemRead  = rd_en;
        bus.funct3   = f3;
        bus.A        = addr;
        bus.WD       = wd;
        exp_q.push_back(exp_rd);
        n = 0;
        #1;
        while (bus.stall && n < 10) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, ".stalls"}, 32'(n), 32'(exp_stalls));
        got = bus.RD;
        check({tag, ".rd"}, got, exp_q.pop_front());
    endtask

    task automatic idle();
        @(negedge clk);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.A        = '0;
        bus.WD       = '0;
        bus.funct3   = 3'b010;
    endtask

    int f0, w0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[32'h0001_0000 >> 2] = 32'hDEAD_BEEF;
        mem[32'h0001_0400 >> 2] = 32'h4444_0000;
        mem[32'h0001_0800 >> 2] = 32'h8888_0000;
        mem[16'h8000]           = 32'h0BAD_F00D;
        mem[16'h8004]           = 32'hCAFE_F00D;
        trigger = 32'd1;

        // Reset held with a live request: everything must stay quiet.
        rst          = 1'b1;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        bus.funct3   = 3'b010;
        bus.A        = 32'h0001_0000;
        bus.WD       = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst.stall", {31'd0, bus.stall}, 32'd0);
        check("rst.fetch", {31'd0, bus.fetch}, 32'd0);
        check("rst.wb", {31'd0, bus.writeback}, 32'd0);
        check("rst.rd", bus.RD, 32'd0);
        check("rst.mem_a", bus.mem_A, 32'd0);
        check("rst.wb_addr", bus.WB_addr, 32'd0);
        check("rst.wb_data", bus.WB_DATA, 32'd0);
        bus.MemRead = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("post_rst.stall", {31'd0, bus.stall}, 32'd0);

        // Cold load miss and repeat hit
        f0 = fetch_cnt; w0 = wb_cnt;
        access("cold_lw", 0, 1, 3'b010, 32'h0001_0000, 0, 32'hDEAD_BEEF, 2);
        check("cold.fetches", 32'(fetch_cnt - f0), 32'd1);
        check("cold.fetch_addr", fetch_addr, 32'h0001_0000);
        check("cold.wbs", 32'(wb_cnt - w0), 32'd0);
        f0 = fetch_cnt;
        access("hit_lw", 0, 1, 3'b010, 32'h0001_0000, 0, 32'hDEAD_BEEF, 0);
        check("hit.fetches", 32'(fetch_cnt - f0), 32'd0);

        // Sub-word loads and byte store
        access("lb", 0, 1, 3'b000, 32'h0001_0003, 0, 32'hFFFF_FFDE, 0);
        access("lbu", 0, 1, 3'b100, 32'h0001_0003, 0, 32'h0000_00DE, 0);
        access("lh", 0, 1, 3'b001, 32'h0001_0002, 0, 32'hFFFF_DEAD, 0);
        access("lhu", 0, 1, 3'b101, 32'h0001_0001, 0, 32'h0000_BEEF, 0);
        f0 = fetch_cnt; w0 = wb_cnt;
        access("sb", 1, 0, 3'b000, 32'h0001_0001, 32'h0000_0012, 32'd0, 0);
        access("lw_after_sb", 0, 1, 3'b010, 32'h0001_0000, 0, 32'hDEAD_12EF, 0);
        check("sb.strobes", 32'((fetch_cnt - f0) + (wb_cnt - w0)), 32'd0);

        // Dirty eviction with LRU in set 0
        access("sw", 1, 0, 3'b010, 32'h0001_0000, 32'h1111_1111, 32'd0, 0);
        access("lw_400", 0, 1, 3'b010, 32'h0001_0400, 0, 32'h4444_0000, 2);
        access("lw_000", 0, 1, 3'b010, 32'h0001_0000, 0, 32'h1111_1111, 0);
        w0 = wb_cnt;
        access("lw_800", 0, 1, 3'b010, 32'h0001_0800, 0, 32'h8888_0000, 2);
        check("clean_evict.wbs", 32'(wb_cnt - w0), 32'd0);
        w0 = wb_cnt;
        access("lw_400_dirty", 0, 1, 3'b010, 32'h0001_0400, 0, 32'h4444_0000, 3);
        check("dirty_evict.wbs", 32'(wb_cnt - w0), 32'd1);
        check("dirty_evict.wb_addr", wb_addr_seen, 32'h0001_0000);
        check("dirty_evict.wb_data", wb_data_seen, 32'h1111_1111);

        // MMIO bypass
        f0 = fetch_cnt; w0 = wb_cnt;
        access("mmio_lw", 0, 1, 3'b010, 32'h0000_00FC, 0, 32'd1, 0);
        check("mmio.mem_a", bus.mem_A, 32'h0000_00FC);
        access("mmio_sw", 1, 0, 3'b010, 32'h0000_00FC, 32'h5, 32'd0, 0);
        check("mmio.strobes", 32'((fetch_cnt - f0) + (wb_cnt - w0)), 32'd0);

        // MemRead and MemWrite together act as a store; prove dirtiness by eviction
        access("rw_both", 1, 1, 3'b010, 32'h0001_0800, 32'h5555_5555, 32'd0, 0);
        access("lw_800_new", 0, 1, 3'b010, 32'h0001_0800, 0, 32'h5555_5555, 0);
        access("lw_400_mru", 0, 1, 3'b010, 32'h0001_0400, 0, 32'h4444_0000, 0);
        w0 = wb_cnt;
        access("lw_20000", 0, 1, 3'b010, 32'h0002_0000, 0, 32'h0BAD_F00D, 3);
        check("both.wbs", 32'(wb_cnt - w0), 32'd1);
        check("both.wb_addr", wb_addr_seen, 32'h0001_0800);
        check("both.wb_data", wb_data_seen, 32'h5555_5555);

        // Reset in the middle of an allocate
        @(negedge clk);
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        bus.funct3   = 3'b010;
        bus.A        = 32'h0002_0010;
        #1;
        check("midrst.detect_stall", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        #1;
        check("midrst.alloc_fetch", {31'd0, bus.fetch}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst.fetch_drop", {31'd0, bus.fetch}, 32'd0);
        check("midrst.stall_drop", {31'd0, bus.stall}, 32'd0);
        bus.MemRead = 1'b0;
        #1 rst = 1'b0;
        access("midrst.reissue", 0, 1, 3'b010, 32'h0002_0010, 0, 32'hCAFE_F00D, 2);
        access("midrst.cold_000", 0, 1, 3'b010, 32'h0001_0000, 0, 32'h1111_1111, 2);

        idle();
        #1;
        check("idle.rd", bus.RD, 32'd0);
        check("idle.stall", {31'd0, bus.stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache.md
# dcache

Two-way set-associative, write-back, write-allocate data cache between the CPU load/store unit and the main data memory. Cache blocks are one 32-bit word, matching the memory's whole-word `fetch` and `writeback` port. The block services byte, half and word loads and stores on hits without stalling. On a miss it runs a small FSM that writes back a dirty victim, fetches the missing word and then completes the access. Address 0x000000FC (the MMIO trigger) bypasses the cache.

## Interface
- `DATA_WIDTH`, 32: word and address width.
- `SETS`, 256: number of sets, a power of two. Index width `IW = log2(SETS)`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request. Takes priority if asserted together with `MemRead`.
- `funct3` input 3: access type. 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores use 000 sb, 001 sh, 010 sw.
- `A` input 32: byte address.
- `WD` input 32: store data, right-aligned.
- `RD` output 32: load data, extended per `funct3`.
- `stall` output 1: CPU must hold `A`, `WD`, `funct3`, `MemRead` and `MemWrite` while this is high.
- `fetch` output 1: memory read strobe.
- `mem_A` output 32: fetch address, word-aligned. Driven to the raw `A` for MMIO.
- `mem_RD` input 32: combinational memory read data.
- `writeback` output 1: memory write strobe. The memory writes on the same `clk` edge.
- `WB_addr` output 32: word-aligned writeback address.
- `WB_DATA` output 32: writeback word.

## Operation
- Address split:
  - Offset `A[1:0]`.
  - Index `A[IW+1:2]`.
  - Tag `A[31:IW+2]`.
- Per set and per way, the cache stores `valid`, `dirty`, the tag and a data word. Each set also stores one `lru` bit naming the least-recently-used way.
- Request is `MemRead | MemWrite`. Hit means some way in the indexed set is valid and its tag matches.
- FSM states:
  - IDLE:
    - Request with hit: a load drives `RD` combinationally from the hit way. A store merges into the hit way at the clock edge and sets `dirty`. In both cases `lru` is set to the other way.
    - Request with miss: select a victim. The victim is way 0 if way 0 is invalid, else way 1 if way 1 is invalid, else the way named by `lru`. Go to WRITEBACK if the victim is valid and dirty, else go to ALLOCATE.
    - No request: stay in IDLE.
  - WRITEBACK: assert `writeback`, with `WB_addr = {victim tag, index, 2'b00}` and `WB_DATA = victim data`. Go to ALLOCATE.
  - ALLOCATE:
    - Assert `fetch` with `mem_A = {A[31:2], 2'b00}`.
    - At the edge, load `mem_RD` into the victim way, set `valid=1`, `dirty=0`, and write the tag.
    - Return to IDLE. The access now hits and completes there, which also updates `lru` and applies a pending store.
- Victim choice is latched on entry to WRITEBACK or ALLOCATE and held until return to IDLE.
- Load extraction:
  - lb/lbu select the byte `A[1:0]`.
  - lh/lhu select the half `A[1]`, ignoring `A[0]`.
  - lw ignores `A[1:0]`.
  - Sign- or zero-extend according to `funct3`.
  - `RD=0` when there is no load or the access is not a hit.
- Store merge:
  - sb writes `WD[7:0]` into byte `A[1:0]`.
  - sh writes `WD[15:0]` into half `A[1]`.
  - sw writes the whole word.
  - Unused `funct3` codes on a store: no write, no dirty.
- MMIO, when `A == 32'h000000FC`:
  - Load: `mem_A = A` and `RD = mem_RD`, with no stall, no allocation and no LRU change.
  - Store: dropped.

## Timing
- `stall` is combinational: `(state != IDLE) | (state == IDLE & request & miss & !MMIO)`.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: 2 stall cycles (IDLE-detect, ALLOCATE).
  - Dirty miss: 3 stall cycles (IDLE-detect, WRITEBACK, ALLOCATE).
- `fetch` and `writeback` are each high for exactly one cycle per miss and are never both high.
- During reset and after it:
  - State is IDLE, and all `valid`, `dirty` and `lru` bits are 0.
  - `fetch=0`, `writeback=0`, `stall=0`, `RD=0`.
  - `mem_A`, `WB_addr` and `WB_DATA` are 0.
- Reset asserted mid-miss aborts the miss. A writeback already clocked into memory stands. A pending store is lost.
- Request dropped while in WRITEBACK/ALLOCATE: the FSM completes the fill, then idles. The fill is harmless.
- Back-to-back hits to the same word: a store at edge N is visible to a load in cycle N+1.
- Two misses to one set: the first fill's way becomes most-recently-used, so the second miss evicts the other way.

## Test plan
- **Cold load miss.** Memory word 0x00010000 = 0xDEADBEEF; issue lw 0x00010000. Required: `stall` high for 2 cycles and `fetch` pulses once with `mem_A=0x00010000`. `RD=0xDEADBEEF` on the third cycle. A repeat lw gives `RD` the same cycle with no stall.
- **Sub-word loads and store.** After the fill above:
  - lb 0x00010003 returns 0xFFFFFFDE.
  - lbu 0x00010003 returns 0x000000DE.
  - lh 0x00010002 returns 0xFFFFDEAD.
  - sb 0x00010001 with WD=0x12, then lw, returns 0xDEAD12EF with no memory strobe.
- **Dirty eviction with LRU.** With 256 sets, addresses 0x00010000, 0x00010400 and 0x00010800 map to set 0.
  - sw 0x00010000 with 0x11111111.
  - lw 0x00010400.
  - lw 0x00010000 (hit; way of 0x00010400 is now LRU).
  - lw 0x00010800 evicts the 0x00010400 line clean: 2 stalls, no `writeback`.
  - lw 0x00010400 evicts the dirty 0x00010000 line: `writeback` with `WB_addr=0x00010000`, `WB_DATA=0x11111111`, 3 stalls.
- **MMIO.** With trigger=1, lw 0x000000FC returns `RD=1` with no stall and no fetch. sw 0x000000FC produces no memory strobe.
- **Reset mid-miss.** Pulse `rst` during ALLOCATE. Required: `fetch` and `stall` drop immediately. Reissuing the same load misses again, with a cold 2-cycle fill.
- **Simultaneous MemRead and MemWrite.** With both high to a cached address, the block behaves as a store: the line is marked dirty and `RD=0`.
